// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hold/flush/bubble sequencer for the 5-stage pipeline registers.
// Optional performance counters are built when PIPE_HZD_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_write_en,
  output logic             mem_wb_write_en,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam logic [1:0] RUN = 2'd0, MEM_WAIT = 2'd1, HALT = 2'd2;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  logic [1:0] state;
  logic [7:0] wcnt;
  logic load_use, frozen, eval;
  assign load_use = ex_memread && ex_rd != 5'd0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
  assign frozen = state == HALT || (state == MEM_WAIT ? !mem_ready : mem_req && !mem_ready);
  assign eval = !frozen;
  // A redirect squashes the ID instruction, so it overrides any load-use stall.
  assign pc_write_en = !reset && eval && (ex_redirect || !load_use);
  assign if_id_write_en = pc_write_en;
  assign if_id_flush = reset || (eval && ex_redirect);
  assign id_ex_flush = reset || (eval && (ex_redirect || load_use));
  assign ex_mem_write_en = !reset && eval;
  assign mem_wb_write_en = !reset && eval;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      wcnt <= 8'd0;
      mem_timeout <= 1'b0;
    end else if (state == MEM_WAIT) begin
      if (mem_ready) state <= RUN;
      else if (wcnt == WAIT_LAST) begin
        state <= HALT;
        mem_timeout <= 1'b1;
      end else wcnt <= wcnt + 8'd1;
    end else if (state != HALT && frozen) begin
      state <= MEM_WAIT;
      wcnt <= 8'd1;
    end
  end
`ifdef PIPE_HZD_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (eval && ex_redirect) flush_cnt <= flush_cnt + CNT_W'(1);
      if (eval && !ex_redirect && load_use) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: vector table, corner sequences and random run against a cycle model.
module tb_pipe_hazard_ctrl;
  localparam int TO = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic ex_memread = 0, ex_redirect = 0, mem_req = 0, mem_ready = 0;
  logic pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, ex_mem_write_en, mem_wb_write_en, mem_timeout;
  logic [31:0] stall_cnt, flush_cnt;
  int total = 0, bad = 0;
  bit m_halt, m_wait, m_to;
  int m_wlen;
  logic [31:0] m_stall, m_flush;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_write_en(ex_mem_write_en), .mem_wb_write_en(mem_wb_write_en),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic memread, redirect, req, ready;
    logic [6:0] ctl;
  } vec_t;

  function automatic logic [6:0] ctl();
    return {pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, ex_mem_write_en, mem_wb_write_en, mem_timeout};
  endfunction

  function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef PIPE_HZD_PERF_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  function automatic bit hazard();
    return ex_memread && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
  endfunction

  function automatic bit m_frozen();
    return m_halt || (m_wait ? !mem_ready : (mem_req && !mem_ready));
  endfunction

  function automatic logic [6:0] model_ctl();
    if (reset) return 7'b0011000;
    if (m_frozen()) return {6'b000000, m_to};
    if (ex_redirect) return {6'b111111, m_to};
    if (hazard()) return {6'b000111, m_to};
    return {6'b110011, m_to};
  endfunction

  task automatic model_clear();
    m_halt = 0; m_wait = 0; m_to = 0; m_wlen = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_edge();
    if (reset || m_halt) return;
    if (m_frozen()) begin
      m_wait = 1;
      m_wlen++;
      if (m_wlen == TO) begin m_halt = 1; m_to = 1; end
    end else begin
      m_wait = 0;
      m_wlen = 0;
      if (ex_redirect) m_flush++;
      else if (hazard()) m_stall++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs1, rs2, rd, input logic mr, rdr, rq, rdy);
    id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd; ex_memread = mr; ex_redirect = rdr; mem_req = rq; mem_ready = rdy;
  endtask

  // Inputs are set just after a rising edge; outputs are checked mid-cycle and the model steps on the edge.
  task automatic step(input string name, input bit use_exp, input logic [6:0] exp);
    @(negedge clk);
    #1;
    if (reset) model_clear();
    if (use_exp) chk({name, "_ctl"}, 32'(ctl()), 32'(exp));
    chk({name, "_model"}, 32'(ctl()), 32'(model_ctl()));
    chk({name, "_stall"}, stall_cnt, perf(m_stall));
    chk({name, "_flush"}, flush_cnt, perf(m_flush));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic async_reset(input string name);
    reset = 1'b1;
    #2;
    model_clear();
    chk({name, "_rst_ctl"}, 32'(ctl()), 32'h18);
    chk({name, "_rst_cnt"}, stall_cnt | flush_cnt, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{0, 0, 0, 0, 0, 0, 1, 7'b1100110};
    tbl[1] = '{0, 5, 5, 1, 0, 0, 1, 7'b0001110};
    tbl[2] = '{0, 5, 5, 0, 0, 0, 1, 7'b1100110};
    tbl[3] = '{0, 3, 0, 1, 0, 0, 1, 7'b1100110};
    tbl[4] = '{0, 5, 5, 1, 1, 0, 1, 7'b1111110};
    tbl[5] = '{7, 2, 7, 1, 0, 0, 1, 7'b0001110};
    tbl[6] = '{3, 4, 9, 1, 0, 0, 1, 7'b1100110};
    tbl[7] = '{1, 2, 3, 0, 0, 1, 1, 7'b1100110};
    tbl[8] = '{8, 8, 8, 0, 1, 1, 1, 7'b1111110};
    model_clear();
    #2;
    chk("reset_ctl", 32'(ctl()), 32'h18);
    chk("reset_cnt", stall_cnt | flush_cnt, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    foreach (tbl[i]) begin
      set_in(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].memread, tbl[i].redirect, tbl[i].req, tbl[i].ready);
      step($sformatf("tbl%0d", i), 1, tbl[i].ctl);
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    step("tbl_cnt", 0, 0);
    chk("tbl_stall_total", stall_cnt, perf(32'd2));
    chk("tbl_flush_total", flush_cnt, perf(32'd2));

    async_reset("wait");
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 1, 0);
      step($sformatf("wait%0d", i), 1, 7'b0000000);
    end
    set_in(0, 0, 0, 0, 0, 1, 1);
    step("wait_ready", 1, 7'b1100110);
    set_in(0, 0, 0, 0, 0, 0, 0);
    step("wait_after", 1, 7'b1100110);

    for (int i = 0; i < 2; i++) begin
      set_in(0, 5, 5, 1, 1, 1, 0);
      step($sformatf("pend%0d", i), 1, 7'b0000000);
    end
    set_in(0, 5, 5, 1, 1, 1, 1);
    step("pend_redirect", 1, 7'b1111110);
    set_in(0, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < TO; i++) begin
      set_in(0, 0, 0, 0, 0, 1, 0);
      step($sformatf("to%0d", i), 1, 7'b0000000);
    end
    step("halt", 1, 7'b0000001);
    set_in(0, 0, 0, 0, 1, 1, 1);
    step("halt_ready", 1, 7'b0000001);
    async_reset("halt");
    set_in(0, 0, 0, 0, 0, 0, 0);
    step("halt_release", 1, 7'b1100110);

    set_in(0, 0, 0, 0, 0, 1, 0);
    step("mid0", 1, 7'b0000000);
    step("mid1", 1, 7'b0000000);
    async_reset("mid");
    set_in(0, 0, 0, 0, 0, 0, 0);
    step("mid_release", 1, 7'b1100110);

    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), ($urandom_range(0, 4) == 0), 1'($urandom), ($urandom_range(0, 3) != 0));
      step("rand", 0, 0);
    end
    reset = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
